// File: rtl/mpmc11_sfifo_rty_if.sv
// mpmc11_sfifo_rty_if: handshake/data bundle between a port front-end and the speculative request FIFO
interface mpmc11_sfifo_rty_if #(
   parameter int WID   = 64,
   parameter int DEPTH = 32
);
   localparam int AW = $clog2(DEPTH);
   logic           wr;
   logic [WID-1:0] din;
   logic           rd;
   logic           cmt;
   logic           rty;
   logic [WID-1:0] dout;
   logic           data_valid;
   logic           empty;
   logic           full;
   logic           almost_full;
   logic           prog_full;
   logic           overflow;
   logic           underflow;
   logic           rst_busy;
   logic [AW:0]    cnt;
   logic [AW:0]    ucnt;
   modport master (
      output wr, din, rd, cmt, rty,
      input  dout, data_valid, empty, full, almost_full, prog_full, overflow, underflow, rst_busy, cnt, ucnt
   );
   modport slave (
      input  wr, din, rd, cmt, rty,
      output dout, data_valid, empty, full, almost_full, prog_full, overflow, underflow, rst_busy, cnt, ucnt
   );
endinterface

// File: rtl/mpmc11_sfifo_rty.sv
// mpmc11_sfifo_rty: FWFT request FIFO with speculative read, commit and retry (rewind to oldest uncommitted)
module mpmc11_sfifo_rty #(
   parameter int WID              = 64,
   parameter int DEPTH            = 32,
   parameter int PROG_FULL_THRESH = DEPTH - 5,
   parameter int AW               = $clog2(DEPTH)
) (
   input logic                  clk,
   input logic                  rst,
   mpmc11_sfifo_rty_if.slave    s
);
   if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0 || AW != $clog2(DEPTH) ||
       PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1) begin : g_bad_param
      $error("mpmc11_sfifo_rty: illegal DEPTH/AW/PROG_FULL_THRESH");
   end
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] L_AFULL = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] L_PFULL = (AW+1)'(PROG_FULL_THRESH);
   logic [WID-1:0] r_mem [DEPTH];
   logic [AW:0]    r_wp, r_rp, r_cp, r_cnt, r_ucnt;
   logic           r_ovf, r_udf, r_b0, r_b1;
   logic           w_ok, w_full, w_empty, w_wr, w_rd, w_cmt, w_rty, w_ovf, w_udf;
   logic [AW:0]    w_wp_n, w_rp_n, w_cp_n;
   always_comb begin
      w_ok    = ~r_b1;
      w_full  = r_cnt == L_DEPTH;
      w_empty = r_wp == r_rp;
      w_rty   = w_ok & s.rty;
      w_wr    = w_ok & s.wr & ~w_full;
      w_rd    = w_ok & s.rd & ~w_empty & ~s.rty;
      w_cmt   = w_ok & s.cmt & (r_ucnt != '0);
      w_ovf   = w_ok & s.wr & w_full;
      w_udf   = w_ok & ((s.rd & w_empty & ~s.rty) | (s.cmt & (r_ucnt == '0)));
      w_wp_n  = r_wp + (AW+1)'(w_wr);
      w_cp_n  = r_cp + (AW+1)'(w_cmt);
      w_rp_n  = w_rty ? w_cp_n : r_rp + (AW+1)'(w_rd);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cp   <= '0;
         r_cnt  <= '0;
         r_ucnt <= '0;
         r_ovf  <= 1'b0;
         r_udf  <= 1'b0;
         r_b0   <= 1'b1;
         r_b1   <= 1'b1;
      end else begin
         r_wp   <= w_wp_n;
         r_rp   <= w_rp_n;
         r_cp   <= w_cp_n;
         r_cnt  <= w_wp_n - w_cp_n;
         r_ucnt <= w_rp_n - w_cp_n;
         r_ovf  <= w_ovf;
         r_udf  <= w_udf;
         r_b0   <= 1'b0;
         r_b1   <= r_b0;
      end
   end
   // storage is never cleared; reset only discards entries by zeroing the pointers
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= s.din;
   end
   assign s.dout        = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign s.data_valid  = ~w_empty;
   assign s.empty       = w_empty;
   assign s.full        = w_full;
   assign s.almost_full = r_cnt >= L_AFULL;
   assign s.prog_full   = r_cnt >= L_PFULL;
   assign s.overflow    = r_ovf;
   assign s.underflow   = r_udf;
   assign s.rst_busy    = r_b1;
   assign s.cnt         = r_cnt;
   assign s.ucnt        = r_ucnt;
endmodule

// File: tb/tb_mpmc11_sfifo_rty.sv
// tb_mpmc11_sfifo_rty: vector table plus scoreboard checks on a DEPTH=32 and a DEPTH=16 instance
module tb_mpmc11_sfifo_rty;
   localparam int W = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mpmc11_sfifo_rty_if #(.WID(W), .DEPTH(32)) ifa ();
   mpmc11_sfifo_rty_if #(.WID(W), .DEPTH(16)) ifb ();
   mpmc11_sfifo_rty #(.WID(W), .DEPTH(32)) ua (.clk(clk), .rst(rst), .s(ifa));
   mpmc11_sfifo_rty #(.WID(W), .DEPTH(16), .PROG_FULL_THRESH(11)) ub (.clk(clk), .rst(rst), .s(ifb));
   typedef struct {
      logic         wr, rd, cmt, rty;
      logic [W-1:0] din;
      logic         dv;
      logic [W-1:0] dout;
      int           cnt, ucnt;
      logic         uf;
   } vec_t;
   vec_t         vt[$];
   logic [W-1:0] sb[$];
   int           total = 0;
   int           bad = 0;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask
   task automatic add(input logic wr, rd, cmt, rty, input logic [W-1:0] din, input logic dv,
                      input logic [W-1:0] dout, input int cnt, ucnt, input logic uf);
      vt.push_back('{wr, rd, cmt, rty, din, dv, dout, cnt, ucnt, uf});
   endtask
   task automatic pop_chk(input string n, input logic [W-1:0] a);
      if (sb.size() == 0) chk({n, "_sb_empty"}, 1, 0);
      else chk(n, a, sb.pop_front());
   endtask
   initial begin
      {ifa.wr, ifa.rd, ifa.cmt, ifa.rty, ifa.din} = '0;
      {ifb.wr, ifb.rd, ifb.cmt, ifb.rty, ifb.din} = '0;
      // reset and rst_busy release
      repeat (2) @(negedge clk);
      chk("rst_empty", ifa.empty, 1);
      chk("rst_dv", ifa.data_valid, 0);
      chk("rst_dout", ifa.dout, 0);
      chk("rst_cnt", ifa.cnt, 0);
      chk("rst_ucnt", ifa.ucnt, 0);
      chk("rst_flags", {ifa.full, ifa.almost_full, ifa.prog_full, ifa.overflow, ifa.underflow}, 0);
      chk("rst_busy", ifa.rst_busy, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("busy_hold", ifa.rst_busy, 1);
      @(negedge clk);
      chk("busy_drop", ifa.rst_busy, 0);
      // basic write/read/commit, underflow, retry, rd+rty+cmt, simultaneous ops
      add(1,0,0,0,16'hA000, 1,16'hA000,1,0,0);
      add(1,0,0,0,16'hA001, 1,16'hA000,2,0,0);
      add(1,0,0,0,16'hA002, 1,16'hA000,3,0,0);
      add(1,0,0,0,16'hA003, 1,16'hA000,4,0,0);
      add(0,1,0,0,0, 1,16'hA001,4,1,0);
      add(0,1,0,0,0, 1,16'hA002,4,2,0);
      add(0,1,0,0,0, 1,16'hA003,4,3,0);
      add(0,1,0,0,0, 0,0,4,4,0);
      for (int i = 3; i >= 0; i--) add(0,0,1,0,0, 0,0,i,i,0);
      add(0,1,0,0,0, 0,0,0,0,1);
      add(0,0,0,0,0, 0,0,0,0,0);
      add(0,0,1,0,0, 0,0,0,0,1);
      add(0,0,0,0,0, 0,0,0,0,0);
      add(0,1,0,1,0, 0,0,0,0,0);
      for (int i = 0; i < 5; i++) add(1,0,0,0,16'hB000+W'(i), 1,16'hB000,i+1,0,0);
      add(0,1,0,0,0, 1,16'hB001,5,1,0);
      add(0,1,0,0,0, 1,16'hB002,5,2,0);
      add(0,1,0,0,0, 1,16'hB003,5,3,0);
      add(0,0,1,0,0, 1,16'hB003,4,2,0);
      add(0,0,0,1,0, 1,16'hB001,4,0,0);
      add(0,1,0,0,0, 1,16'hB002,4,1,0);
      add(0,1,0,0,0, 1,16'hB003,4,2,0);
      add(0,1,0,0,0, 1,16'hB004,4,3,0);
      add(0,1,0,0,0, 0,0,4,4,0);
      for (int i = 3; i >= 0; i--) add(0,0,1,0,0, 0,0,i,i,0);
      add(1,0,0,0,16'hC000, 1,16'hC000,1,0,0);
      add(1,0,0,0,16'hC001, 1,16'hC000,2,0,0);
      add(0,1,0,0,0, 1,16'hC001,2,1,0);
      add(0,1,0,0,0, 0,0,2,2,0);
      add(0,1,1,1,0, 1,16'hC001,1,0,0);
      add(0,1,0,0,0, 0,0,1,1,0);
      add(0,0,1,0,0, 0,0,0,0,0);
      add(1,0,0,0,16'hD000, 1,16'hD000,1,0,0);
      add(1,1,0,0,16'hD001, 1,16'hD001,2,1,0);
      add(0,1,1,0,0, 0,0,1,1,0);
      add(0,0,1,0,0, 0,0,0,0,0);
      foreach (vt[i]) begin
         {ifa.wr, ifa.rd, ifa.cmt, ifa.rty, ifa.din} = {vt[i].wr, vt[i].rd, vt[i].cmt, vt[i].rty, vt[i].din};
         @(negedge clk);
         chk($sformatf("v%0d_dv", i), ifa.data_valid, vt[i].dv);
         chk($sformatf("v%0d_dout", i), ifa.dout, vt[i].dout);
         chk($sformatf("v%0d_cnt", i), ifa.cnt, vt[i].cnt);
         chk($sformatf("v%0d_ucnt", i), ifa.ucnt, vt[i].ucnt);
         chk($sformatf("v%0d_uf", i), ifa.underflow, vt[i].uf);
         chk($sformatf("v%0d_of", i), ifa.overflow, 0);
      end
      {ifa.wr, ifa.rd, ifa.cmt, ifa.rty, ifa.din} = '0;
      // fill DEPTH=32 past full, then read all (full & empty together), then commit all
      for (int k = 1; k <= 33; k++) begin
         ifa.wr = 1'b1;
         ifa.din = 16'hF000 + W'(k);
         if (k <= 32) sb.push_back(ifa.din);
         @(negedge clk);
         chk($sformatf("fill%0d_cnt", k), ifa.cnt, k > 32 ? 32 : k);
         chk($sformatf("fill%0d_full", k), ifa.full, k >= 32);
         chk($sformatf("fill%0d_afull", k), ifa.almost_full, k >= 31);
         chk($sformatf("fill%0d_pfull", k), ifa.prog_full, k >= 27);
         chk($sformatf("fill%0d_ovf", k), ifa.overflow, k == 33);
      end
      ifa.wr = 1'b0;
      @(negedge clk);
      chk("ovf_pulse_end", ifa.overflow, 0);
      chk("ovf_cnt", ifa.cnt, 32);
      for (int k = 0; k < 32; k++) begin
         chk("fill_rd_dv", ifa.data_valid, 1);
         pop_chk("fill_rd_data", ifa.dout);
         ifa.rd = 1'b1;
         @(negedge clk);
      end
      ifa.rd = 1'b0;
      chk("fe_empty", ifa.empty, 1);
      chk("fe_full", ifa.full, 1);
      chk("fe_ucnt", ifa.ucnt, 32);
      ifa.cmt = 1'b1;
      @(negedge clk);
      chk("cmt_full_drop", ifa.full, 0);
      chk("cmt_cnt", ifa.cnt, 31);
      repeat (31) @(negedge clk);
      ifa.cmt = 1'b0;
      chk("drain_cnt", ifa.cnt, 0);
      chk("drain_ucnt", ifa.ucnt, 0);
      @(negedge clk);
      chk("drain_uf", ifa.underflow, 0);
      // stream 100 entries through DEPTH=16, committing 2 cycles after each read
      begin
         int nw = 0, nr = 0, cyc = 0;
         logic [1:0] hist = '0;
         while (nr < 100 && cyc < 3000) begin
            chk("stream_ovf", ifb.overflow, 0);
            chk("stream_udf", ifb.underflow, 0);
            ifb.rd = ifb.data_valid;
            if (ifb.data_valid) begin
               pop_chk("stream_data", ifb.dout);
               nr++;
            end
            ifb.cmt = hist[1];
            hist = {hist[0], ifb.rd};
            ifb.wr = (nw < 100) && !ifb.full;
            if (ifb.wr) begin
               ifb.din = W'(nw * 7 + 3);
               sb.push_back(ifb.din);
               nw++;
            end
            @(negedge clk);
            cyc++;
         end
         chk("stream_timeout", cyc < 3000, 1);
         chk("stream_reads", nr, 100);
         ifb.wr = 1'b0;
         ifb.rd = 1'b0;
         repeat (2) begin
            ifb.cmt = hist[1];
            hist = {hist[0], 1'b0};
            @(negedge clk);
         end
         ifb.cmt = 1'b0;
         chk("stream_cnt", ifb.cnt, 0);
         chk("stream_ucnt", ifb.ucnt, 0);
         chk("stream_empty", ifb.empty, 1);
      end
      // reset in the middle of activity
      for (int i = 0; i < 5; i++) begin
         ifb.wr = 1'b1;
         ifb.din = 16'h5000 + W'(i);
         @(negedge clk);
      end
      ifb.wr = 1'b0;
      ifb.rd = 1'b1;
      repeat (2) @(negedge clk);
      ifb.rd = 1'b0;
      chk("pre_rst_cnt", ifb.cnt, 5);
      chk("pre_rst_ucnt", ifb.ucnt, 2);
      rst = 1'b1;
      ifb.wr = 1'b1;
      ifb.din = 16'hDEAD;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_empty", ifb.empty, 1);
      chk("mrst_cnt", ifb.cnt, 0);
      chk("mrst_ucnt", ifb.ucnt, 0);
      chk("mrst_busy1", ifb.rst_busy, 1);
      @(negedge clk);
      chk("mrst_busy2", ifb.rst_busy, 1);
      ifb.wr = 1'b0;
      @(negedge clk);
      chk("mrst_busy_end", ifb.rst_busy, 0);
      chk("mrst_wr_ignored_cnt", ifb.cnt, 0);
      chk("mrst_wr_ignored_dv", ifb.data_valid, 0);
      chk("mrst_no_ovf", ifb.overflow, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mpmc11_sfifo_rty.md
Name: mpmc11_sfifo_rty

Overview:
- Single-clock, parametrised first-word-fall-through (FWFT) request FIFO for the mpmc11 port front-ends.
- Generalises the port request FIFO to arbitrary width, depth and thresholds.
- Adds speculative read with commit/retry: entries popped by the controller stay resident until committed, and a retry re-presents every uncommitted entry in original order.
- Sits between a port's request register and the mpmc11 state machine when both run on the memory clock.

Parameters:
- WID, 64, entry width in bits; normally $bits(mpmc11_fifoe_t).
- DEPTH, 32, number of entries; power of two, 4..1024. Elaboration fails otherwise.
- PROG_FULL_THRESH, DEPTH-5, prog_full asserts when cnt >= this value; range 1..DEPTH-1.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- din  in  WID  write data
- rd  in  1  speculative pop of the head entry
- cmt  in  1  commit: retire the oldest speculatively-read entry
- rty  in  1  retry: rewind the read pointer to the oldest uncommitted entry
- dout  out  WID  head entry (FWFT); 0 when data_valid=0
- data_valid  out  1  dout holds a valid unread entry
- empty  out  1  no unread entries
- full  out  1  cnt == DEPTH
- almost_full  out  1  cnt >= DEPTH-1
- prog_full  out  1  cnt >= PROG_FULL_THRESH
- overflow  out  1  one-cycle pulse: the previous-cycle write was rejected
- underflow  out  1  one-cycle pulse: the previous-cycle rd or cmt was rejected
- rst_busy  out  1  high while rst is high and for 1 cycle after it drops
- cnt  out  AW+1  occupied entries (wp-cp)
- ucnt  out  AW+1  read but uncommitted entries (rp-cp)

Behaviour:
- Pointers: wp, rp and cp are each AW+1 bits wide. The MSB is a wrap bit, and all subtraction is modulo 2^(AW+1).
  - Invariants: cp <= rp <= wp, and wp-cp <= DEPTH.
- Reset (rst=1 at the clock edge): wp=rp=cp=0, empty=1, data_valid=0, dout=0, full=almost_full=prog_full=0, overflow=underflow=0, cnt=ucnt=0, rst_busy=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries, including uncommitted ones.
- While rst_busy=1, wr, rd, cmt and rty are ignored. None of them generate overflow or underflow.
- All flags are registered or derived from registered pointers only. There is no combinational path from any input to any output.
- Write: wr & ~full stores din at mem[wp[AW-1:0]] and increments wp.
  - wr & full: no state change; overflow=1 next cycle.
  - full is evaluated on current state, so a same-cycle cmt does not admit the write.
- FWFT: empty = (wp==rp); data_valid = ~empty; dout = mem[rp[AW-1:0]] when data_valid, else 0.
  - Write-to-data_valid latency on an empty FIFO: 1 cycle.
- Read: rd & ~empty increments rp. rd & empty: no change; underflow=1 next cycle.
- Commit: cmt & (ucnt!=0) increments cp and frees one slot; full drops the next cycle.
  - cmt & (ucnt==0): no change; underflow=1 next cycle.
- Retry: rty sets rp <= cp, after any same-cycle commit (rp <= cp+1 if that commit is accepted).
  - rd in the same cycle as rty is ignored and raises no underflow.
  - dout shows the oldest uncommitted entry the next cycle.
- Simultaneous wr with rd/cmt/rty: all accepted operations apply in the same cycle. cnt = wp-cp and ucnt = rp-cp are computed from the next-state pointers.
- Wrap-around: addresses use the low AW bits, and full/empty use the wrap bit. The sequence DEPTH writes, DEPTH reads, DEPTH commits must return to empty with the wrap bit toggled.
- Occupancy: uncommitted entries count toward cnt and full. A FIFO with DEPTH entries read but uncommitted is full=1 and empty=1 at the same time. This state is legal.

Test Plan:
- Reset, then write A0..A3 on consecutive cycles -> data_valid=1 one cycle after the first write, dout=A0, cnt=4; 4 rd + 4 cmt -> empty=1, cnt=0, ucnt=0.
- DEPTH=32: write 33 entries back-to-back -> full=1 after the 32nd, overflow pulse after the 33rd, cnt=32; prog_full=1 from cnt=27; almost_full=1 from cnt=31.
- Write B0..B4; rd x3; cmt x1; rty -> next cycle dout=B1, ucnt=0, cnt=4; rd x4 -> dout sequence B1,B2,B3,B4.
- Same cycle rd+rty+cmt with 2 read/uncommitted entries C0,C1 -> cp=1, rp=1, dout=C1, no underflow.
- rd on empty and cmt with ucnt=0 -> underflow pulses for exactly one cycle each; pointers unchanged.
- Stream 100 entries through DEPTH=16, committing each 2 cycles after its read -> data in order, no overflow/underflow, wrap bit toggles correctly; assert rst mid-stream -> next cycle empty=1, cnt=0, rst_busy=1 for 2 cycles total, and a wr during rst_busy is not stored.
